// File: rtl/bt_pkg.sv
// Shared Bluetooth module definitions: init-sequencer states, pin bundle
// and default power-up timing.
package bt_pkg;

    typedef enum logic [2:0] {
        S_OFF,
        S_PWR,
        S_BOOT,
        S_WAIT,
        S_DONE,
        S_ERR
    } bt_init_state_t;

    typedef struct packed {
        logic pwr_en;
        logic rst_n;
        logic key;
        logic busy;
        logic done;
        logic err;
    } bt_pins_t;

    localparam int BT_CNT_W     = 24;
    localparam int BT_OFF_DLY   = 1000;
    localparam int BT_PWR_DLY   = 1000;
    localparam int BT_KEY_DLY   = 1000;
    localparam int BT_READY_TO  = 100000;
    localparam int BT_MAX_RETRY = 2;

    function automatic bt_pins_t bt_decode(bt_init_state_t st);
        bt_pins_t p;
        p = '0;
        case (st)
            S_OFF:  p.busy = 1'b1;
            S_PWR:  begin
                p.pwr_en = 1'b1;
                p.busy   = 1'b1;
            end
            S_BOOT: begin
                p.pwr_en = 1'b1;
                p.rst_n  = 1'b1;
                p.busy   = 1'b1;
            end
            S_WAIT: begin
                p.pwr_en = 1'b1;
                p.rst_n  = 1'b1;
                p.key    = 1'b1;
                p.busy   = 1'b1;
            end
            S_DONE: begin
                p.pwr_en = 1'b1;
                p.rst_n  = 1'b1;
                p.key    = 1'b1;
                p.done   = 1'b1;
            end
            S_ERR:  p.err = 1'b1;
            default: p.busy = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bt_sync2.sv
// Generic two-flop synchroniser with synchronous active-low reset.
module bt_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/bt_init_sequencer.sv
// Power / reset / key sequencer for the Bluetooth UART module.
// Define BT_INIT_READY_CHECK_EN to check STATE readiness with retries.
module bt_init_sequencer
    import bt_pkg::*;
#(
    parameter int CNT_W     = BT_CNT_W,
    parameter int OFF_DLY   = BT_OFF_DLY,
    parameter int PWR_DLY   = BT_PWR_DLY,
    parameter int KEY_DLY   = BT_KEY_DLY,
    parameter int READY_TO  = BT_READY_TO,
    parameter int MAX_RETRY = BT_MAX_RETRY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bt_state,
    output logic bt_pwr_en,
    output logic bt_rst_n,
    output logic bt_key,
    output logic busy,
    output logic init_done,
    output logic init_err
);

    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_DLY - 1);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DLY - 1);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_DLY - 1);
    localparam logic [CNT_W-1:0] RDY_LAST = CNT_W'(READY_TO - 1);

    bt_init_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bt_pins_t         pins_q, pins_d;

`ifdef BT_INIT_READY_CHECK_EN
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

    logic [RTY_W-1:0] retry_q, retry_d;
    logic             ready;

    bt_sync2 #(.W(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bt_state),
        .q     (ready)
    );
`else
    logic unused_bt_state;
    assign unused_bt_state = bt_state;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
`ifdef BT_INIT_READY_CHECK_EN
        retry_d = retry_q;
`endif
        case (state_q)
            S_OFF:  if (cnt_q == OFF_LAST) state_d = S_PWR;
            S_PWR:  if (cnt_q == PWR_LAST) state_d = S_BOOT;
            S_BOOT: if (cnt_q == KEY_LAST) state_d = S_WAIT;
            S_WAIT: begin
`ifdef BT_INIT_READY_CHECK_EN
                // Ready beats a coincident timeout.
                if (ready) begin
                    state_d = S_DONE;
                end else if (cnt_q == RDY_LAST) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_OFF;
                    end else begin
                        state_d = S_ERR;
                    end
                end
`else
                if (cnt_q == RDY_LAST) state_d = S_DONE;
`endif
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_OFF;
`ifdef BT_INIT_READY_CHECK_EN
                    retry_d = '0;
`endif
                end
            end
            default: state_d = S_OFF;
        endcase
        if (state_d != state_q) cnt_d = '0;

        // Pins follow the next state so they flip with the state register.
        pins_d = bt_decode(state_d);
`ifndef BT_INIT_READY_CHECK_EN
        pins_d.err = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            pins_q  <= bt_decode(S_OFF);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pins_q  <= pins_d;
        end
    end

`ifdef BT_INIT_READY_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) retry_q <= '0;
        else        retry_q <= retry_d;
    end
`endif

    assign bt_pwr_en = pins_q.pwr_en;
    assign bt_rst_n  = pins_q.rst_n;
    assign bt_key    = pins_q.key;
    assign busy      = pins_q.busy;
    assign init_done = pins_q.done;
    assign init_err  = pins_q.err;

endmodule

// File: tb/tb_bt_init_sequencer.sv
// Directed bench for bt_init_sequencer with short delays; covers both
// builds of BT_INIT_READY_CHECK_EN.
module tb_bt_init_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic bt_state = 1'b0;
    logic bt_pwr_en, bt_rst_n, bt_key, busy, init_done, init_err;

    int k = 0;
    int n_cmp = 0;
    int n_bad = 0;

    bt_init_sequencer #(
        .CNT_W     (24),
        .OFF_DLY   (4),
        .PWR_DLY   (8),
        .KEY_DLY   (16),
        .READY_TO  (32),
        .MAX_RETRY (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bt_state  (bt_state),
        .bt_pwr_en (bt_pwr_en),
        .bt_rst_n  (bt_rst_n),
        .bt_key    (bt_key),
        .busy      (busy),
        .init_done (init_done),
        .init_err  (init_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) tick();
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic p, input logic r,
                           input logic ky, input logic b, input logic d,
                           input logic e);
        chk({tag, ".pwr_en"}, bt_pwr_en, p);
        chk({tag, ".rst_n"}, bt_rst_n, r);
        chk({tag, ".key"}, bt_key, ky);
        chk({tag, ".busy"}, busy, b);
        chk({tag, ".done"}, init_done, d);
        chk({tag, ".err"}, init_err, e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 1, 0, 0);
        rst_n = 1'b1;
        k = 0;

`ifdef BT_INIT_READY_CHECK_EN
        run_to(3);  chk("s1.pwr_pre", bt_pwr_en, 0);
        run_to(4);  chk("s1.pwr_up", bt_pwr_en, 1);
        run_to(11); chk("s1.rst_pre", bt_rst_n, 0);
        run_to(12); chk("s1.rst_up", bt_rst_n, 1);
        run_to(27); chk("s1.key_pre", bt_key, 0);
        run_to(28); chk("s1.key_up", bt_key, 1);
        chk("s1.busy_wait", busy, 1);
        run_to(30); bt_state = 1'b1;
        run_to(32); chk("s1.done_pre", init_done, 0);
        run_to(33); chk_all("s1.done", 1, 1, 1, 0, 1, 0);

        bt_state = 1'b0;
        pulse_start();
        chk_all("s2.restart", 0, 0, 0, 1, 0, 0);
        run_to(9);  start = 1'b1;
        tick();     start = 1'b0;
        run_to(11); chk_all("s2.ign", 1, 0, 0, 1, 0, 0);
        run_to(12); chk("s2.rst_up", bt_rst_n, 1);
        run_to(27); chk("s2.key_pre", bt_key, 0);
        run_to(28); chk("s2.key_up", bt_key, 1);
        run_to(30); bt_state = 1'b1;
        run_to(32); chk("s2.done_pre", init_done, 0);
        run_to(33); chk_all("s2.done", 1, 1, 1, 0, 1, 0);

        bt_state = 1'b0;
        pulse_start();
        run_to(15); chk("s3.boot", bt_rst_n, 1);
        rst_n = 1'b0;
        tick();
        chk_all("s3.midrst", 0, 0, 0, 1, 0, 0);
        rst_n = 1'b1;
        k = 0;
        run_to(3);   chk("s3.pwr_pre", bt_pwr_en, 0);
        run_to(4);   chk("s3.pwr_up", bt_pwr_en, 1);
        run_to(59);  chk("s3.key_t1", bt_key, 1);
        run_to(60);  chk_all("s3.retry1", 0, 0, 0, 1, 0, 0);
        run_to(64);  chk("s3.pwr_r1", bt_pwr_en, 1);
        run_to(120); chk_all("s3.retry2", 0, 0, 0, 1, 0, 0);
        run_to(179); chk_all("s3.last", 1, 1, 1, 1, 0, 0);
        run_to(180); chk_all("s3.err", 0, 0, 0, 0, 0, 1);
        run_to(185); chk("s3.err_hold", init_err, 1);

        pulse_start();
        chk_all("s4.restart", 0, 0, 0, 1, 0, 0);
        run_to(57); bt_state = 1'b1;
        run_to(59); chk_all("s4.pre", 1, 1, 1, 1, 0, 0);
        run_to(60); chk_all("s4.race", 1, 1, 1, 0, 1, 0);
        bt_state = 1'b0;
        run_to(66); chk("s4.loss_ign", init_done, 1);
`else
        bt_state = 1'b0;
        run_to(3);  chk("n1.pwr_pre", bt_pwr_en, 0);
        run_to(4);  chk("n1.pwr_up", bt_pwr_en, 1);
        run_to(12); chk("n1.rst_up", bt_rst_n, 1);
        run_to(28); chk("n1.key_up", bt_key, 1);
        run_to(59); chk_all("n1.pre", 1, 1, 1, 1, 0, 0);
        run_to(60); chk_all("n1.done", 1, 1, 1, 0, 1, 0);
        run_to(200); chk_all("n1.hold", 1, 1, 1, 0, 1, 0);

        pulse_start();
        chk_all("n2.restart", 0, 0, 0, 1, 0, 0);
        run_to(4);  chk("n2.pwr_up", bt_pwr_en, 1);
        run_to(59); chk("n2.done_pre", init_done, 0);
        run_to(60); chk_all("n2.done", 1, 1, 1, 0, 1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
